// File: rtl/cpu_opponent.sv
// cpu_opponent: automated O player for the tic-tac-toe VGA game.
//
// On O's turn the player waits a visible think delay, scans the eight board
// lines one per cycle for a winning or blocking cell, picks a move and
// presents it through a valid/ack handshake. A rejected move triggers a
// rescan without repeating the think delay.
//
// Optional feature macro: CPU_LFSR_EN
//   defined   : fallback move (no win/block) is the first empty cell scanning
//               cyclically upward from a pseudo-random start cell.
//   undefined : fallback is centre, then corners 1,3,7,9, then edges 2,4,6,8.
//
// Ports:
//   clk        in   25 MHz pixel clock
//   rst        in   asynchronous reset, active-high
//   enable     in   CPU player selected; 0 forces IDLE
//   board      in   cells 1..9 packed, cell k at bits [2k-1:2k-2]
//   cpu_turn   in   game expects O's move
//   game_over  in   winner or draw declared
//   move_ack   in   game accepted the presented move (1-cycle pulse)
//   move_rej   in   game rejected the presented move (1-cycle pulse)
//   move_valid out  move request presented
//   move_pos   out  requested cell 1..9; 0 when idle
//   busy       out  high in any state other than IDLE
module cpu_opponent #(
  parameter int         THINK_CYCLES = 25000000,
  parameter logic [1:0] CPU_MARK     = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [17:0] board,
  input  logic        cpu_turn,
  input  logic        game_over,
  input  logic        move_ack,
  input  logic        move_rej,
  output logic        move_valid,
  output logic [3:0]  move_pos,
  output logic        busy
);

  localparam int              CNT_W      = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] THINK_LAST = CNT_W'(THINK_CYCLES - 1);
  localparam logic [1:0]      OPP_MARK   = 2'b01;
  localparam logic [1:0]      EMPTY      = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_THINK, S_SCAN, S_PICK, S_ISSUE, S_WAIT_TURN
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       line_q, line_d;
  logic [3:0]       win_q, win_d;
  logic [3:0]       blk_q, blk_d;
  logic             move_valid_q, move_valid_d;
  logic [3:0]       move_pos_q, move_pos_d;
  logic             busy_q, busy_d;

  // Code of cell k (1..9); k=0 is never passed in.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] k);
    logic [4:0] lo;
    lo = {k, 1'b0} - 5'd2;
    return b[lo +: 2];
  endfunction

  // The three cells of scan line idx, packed {first, second, third}.
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    return {4'd1, 4'd2, 4'd3};
      3'd1:    return {4'd4, 4'd5, 4'd6};
      3'd2:    return {4'd7, 4'd8, 4'd9};
      3'd3:    return {4'd1, 4'd4, 4'd7};
      3'd4:    return {4'd2, 4'd5, 4'd8};
      3'd5:    return {4'd3, 4'd6, 4'd9};
      3'd6:    return {4'd1, 4'd5, 4'd9};
      default: return {4'd3, 4'd5, 4'd7};
    endcase
  endfunction

`ifdef CPU_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Galois form of x^8 + x^6 + x^5 + x^4 + 1, shifting right.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'h5A;
    else     lfsr_q <= lfsr_d;
  end

  // First empty cell scanning cyclically upward from (lfsr mod 9)+1.
  // Iterating from the far end lets the nearest empty cell overwrite last.
  function automatic logic [3:0] pick_fallback(input logic [17:0] b, input logic [7:0] r);
    int start;
    int c;
    logic [3:0] res;
    res   = 4'd0;
    start = int'(r) % 9;
    for (int j = 8; j >= 0; j--) begin
      c = ((start + j) % 9) + 1;
      if (cell_at(b, 4'(c)) == EMPTY) res = 4'(c);
    end
    return res;
  endfunction
`else
  // Centre, corners, edges; iterating from lowest priority upward lets the
  // most preferred empty cell overwrite last.
  function automatic logic [3:0] pick_fallback(input logic [17:0] b);
    logic [35:0] order;
    logic [3:0]  res;
    order = {4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8};
    res   = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (cell_at(b, order[i*4 +: 4]) == EMPTY) res = order[i*4 +: 4];
    end
    return res;
  endfunction
`endif

  logic [11:0] lc;
  logic [1:0]  v0, v1, v2;
  logic [1:0]  n_cpu, n_opp, n_emp;
  logic [3:0]  empty_cell;
  logic [3:0]  pick;
  logic        abort;

  always_comb begin
    lc    = line_cells(line_q);
    v0    = cell_at(board, lc[11:8]);
    v1    = cell_at(board, lc[7:4]);
    v2    = cell_at(board, lc[3:0]);
    n_cpu = 2'(v0 == CPU_MARK) + 2'(v1 == CPU_MARK) + 2'(v2 == CPU_MARK);
    n_opp = 2'(v0 == OPP_MARK) + 2'(v1 == OPP_MARK) + 2'(v2 == OPP_MARK);
    n_emp = 2'(v0 == EMPTY) + 2'(v1 == EMPTY) + 2'(v2 == EMPTY);
    if (v0 == EMPTY)      empty_cell = lc[11:8];
    else if (v1 == EMPTY) empty_cell = lc[7:4];
    else                  empty_cell = lc[3:0];

    if (win_q != 4'd0)      pick = win_q;
    else if (blk_q != 4'd0) pick = blk_q;
    else
`ifdef CPU_LFSR_EN
                            pick = pick_fallback(board, lfsr_q);
`else
                            pick = pick_fallback(board);
`endif

    abort = ~enable | game_over;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    win_d        = win_q;
    blk_d        = blk_q;
    move_valid_d = move_valid_q;
    move_pos_d   = move_pos_q;

    case (state_q)
      S_IDLE: begin
        move_valid_d = 1'b0;
        move_pos_d   = 4'd0;
        cnt_d        = '0;
        if (enable && cpu_turn && !game_over) begin
          state_d = S_THINK;
          line_d  = 3'd0;
          win_d   = 4'd0;
          blk_d   = 4'd0;
        end
      end
      S_THINK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == THINK_LAST) begin
          state_d = S_SCAN;
          line_d  = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          // Only the first qualifying line of each kind is kept.
          if (win_q == 4'd0 && n_cpu == 2'd2 && n_emp == 2'd1) win_d = empty_cell;
          if (blk_q == 4'd0 && n_opp == 2'd2 && n_emp == 2'd1) blk_d = empty_cell;
          if (line_q == 3'd7) state_d = S_PICK;
          else                line_d  = line_q + 3'd1;
        end
      end
      S_PICK: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          move_pos_d   = pick;
          move_valid_d = (pick != 4'd0);
          state_d      = (pick != 4'd0) ? S_ISSUE : S_WAIT_TURN;
        end
      end
      S_ISSUE: begin
        // Abort takes precedence over a same-cycle ack; ack beats reject.
        if (abort) begin
          state_d = S_IDLE;
        end else if (move_ack) begin
          move_valid_d = 1'b0;
          state_d      = S_WAIT_TURN;
        end else if (move_rej) begin
          move_valid_d = 1'b0;
          line_d       = 3'd0;
          win_d        = 4'd0;
          blk_d        = 4'd0;
          state_d      = S_SCAN;
        end
      end
      S_WAIT_TURN: begin
        // Hold off until the game has taken the turn away, so the same turn
        // cannot be played twice.
        if (!cpu_turn || abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      move_valid_d = 1'b0;
      move_pos_d   = 4'd0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      line_q       <= 3'd0;
      win_q        <= 4'd0;
      blk_q        <= 4'd0;
      move_valid_q <= 1'b0;
      move_pos_q   <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      win_q        <= win_d;
      blk_q        <= blk_d;
      move_valid_q <= move_valid_d;
      move_pos_q   <= move_pos_d;
      busy_q       <= busy_d;
    end
  end

  assign move_valid = move_valid_q;
  assign move_pos   = move_pos_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cpu_opponent.sv
// Directed testbench for cpu_opponent with THINK_CYCLES=4 (default build).
// Board encoding: X (opponent) = 2'b01, O (CPU) = 2'b10, cell k at [2k-1:2k-2].
module tb_cpu_opponent;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [17:0] board;
  logic        cpu_turn;
  logic        game_over;
  logic        move_ack;
  logic        move_rej;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  cpu_opponent #(.THINK_CYCLES(4), .CPU_MARK(2'b10)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .board      (board),
    .cpu_turn   (cpu_turn),
    .game_over  (game_over),
    .move_ack   (move_ack),
    .move_rej   (move_rej),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // Start a turn from IDLE and expect the request 13 cycles after THINK entry.
  task automatic run_move(input logic [17:0] b, input logic [3:0] exp_pos, input string tag);
    board    = b;
    cpu_turn = 1'b1;
    tick();
    check({tag, "_busy_think"}, 32'(busy), 32'd1);
    repeat (12) tick();
    check({tag, "_valid_early"}, 32'(move_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(move_valid), 32'd1);
    check({tag, "_pos"}, 32'(move_pos), 32'(exp_pos));
  endtask

  task automatic finish_move(input logic [3:0] exp_pos, input string tag);
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check({tag, "_valid_after_ack"}, 32'(move_valid), 32'd0);
    check({tag, "_pos_after_ack"}, 32'(move_pos), 32'(exp_pos));
    tick();
    check({tag, "_busy_wait"}, 32'(busy), 32'd1);
    cpu_turn = 1'b0;
    tick();
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_pos_idle"}, 32'(move_pos), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    rst       = 1'b1;
    enable    = 1'b0;
    board     = 18'h0;
    cpu_turn  = 1'b0;
    game_over = 1'b0;
    move_ack  = 1'b0;
    move_rej  = 1'b0;
    tick();
    tick();
    check("reset_valid", 32'(move_valid), 32'd0);
    check("reset_pos", 32'(move_pos), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst    = 1'b0;
    enable = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Empty board: centre.
    run_move(18'h00000, 4'd5, "empty");
    finish_move(4'd5, "empty");

    // X at 1,2; O at 5: block at 3.
    run_move(18'h00205, 4'd3, "block");
    finish_move(4'd3, "block");

    // O at 1,5; X at 2,3: win on diagonal at 9.
    run_move(18'h00216, 4'd9, "win");
    finish_move(4'd9, "win");

    // X at 1,2 (block 3 found first), O at 4,5 (win 6): win has priority.
    run_move(18'h00285, 4'd6, "win_over_block");
    finish_move(4'd6, "win_over_block");

    // Cell 5 coded 2'b11 counts as occupied: first corner.
    run_move(18'h00300, 4'd1, "code11");
    finish_move(4'd1, "code11");

    // X at 5: corner 1; reject while cell 1 becomes occupied -> rescan to 3.
    run_move(18'h00100, 4'd1, "rej");
    board    = 18'h00103;
    move_rej = 1'b1;
    tick();
    move_rej = 1'b0;
    check("rej_valid_low", 32'(move_valid), 32'd0);
    check("rej_busy", 32'(busy), 32'd1);
    repeat (8) tick();
    check("rej_valid_early", 32'(move_valid), 32'd0);
    tick();
    check("rej_valid_again", 32'(move_valid), 32'd1);
    check("rej_pos_again", 32'(move_pos), 32'd3);
    finish_move(4'd3, "rej");

    // game_over with a same-cycle ack during ISSUE: straight to IDLE.
    run_move(18'h00000, 4'd5, "gover");
    game_over = 1'b1;
    move_ack  = 1'b1;
    cpu_turn  = 1'b0;
    tick();
    move_ack  = 1'b0;
    check("gover_valid", 32'(move_valid), 32'd0);
    check("gover_pos", 32'(move_pos), 32'd0);
    check("gover_busy", 32'(busy), 32'd0);
    game_over = 1'b0;
    tick();
    check("gover_stay_idle", 32'(busy), 32'd0);

    // enable dropped during THINK aborts.
    board    = 18'h0;
    cpu_turn = 1'b1;
    tick();
    tick();
    check("abort_think_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    tick();
    check("abort_think_busy", 32'(busy), 32'd0);
    cpu_turn = 1'b0;
    enable   = 1'b1;
    tick();

    // Asynchronous reset in the middle of SCAN.
    cpu_turn = 1'b1;
    tick();
    repeat (6) tick();
    check("scan_busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_valid", 32'(move_valid), 32'd0);
    check("async_rst_pos", 32'(move_pos), 32'd0);
    cpu_turn = 1'b0;
    tick();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (move_valid || busy) seen_valid = 1'b1;
    end
    check("post_rst_no_request", 32'(seen_valid), 32'd0);

    // Fresh turn after reset works normally.
    run_move(18'h00000, 4'd5, "post_rst");
    finish_move(4'd5, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_opponent.md
Name: cpu_opponent

Overview:
- Automated O player for the tic-tac-toe VGA game; sits upstream of the game logic, in parallel with the button controller, and drives the O move request.
- On O's turn it waits a visible think delay, then scans the board for a win or block. Otherwise it falls back to a fixed cell preference.
- Issues one move through a valid/ack handshake and retries if the move is rejected.
- Runs in the 25 MHz pixel clock domain.

Parameters:
- THINK_CYCLES, 25000000, delay in clk cycles before scanning; 1 s at 25 MHz; minimum 1.
- CPU_MARK, 2'b10, cell code owned by this player. The opponent code is 2'b01; 2'b00 is empty.

Ports:
- clk  in  1  25 MHz pixel clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  CPU player selected; 0 forces IDLE
- board  in  18  cells 1..9 packed; cell k at bits [2k-1:2k-2]
- cpu_turn  in  1  1 when the game expects O's move
- game_over  in  1  winner or draw declared
- move_ack  in  1  game accepted the presented move (1-cycle pulse)
- move_rej  in  1  game rejected the presented move (1-cycle pulse)
- move_valid  out  1  move request presented
- move_pos  out  4  cell 1..9; 0 when idle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, move_valid=0, move_pos=0, busy=0, think counter=0, line index=0, candidate registers cleared.
- States: IDLE, THINK, SCAN, PICK, ISSUE, WAIT_TURN.
- IDLE -> THINK when enable & cpu_turn & ~game_over; the counter loads 0.
- THINK: the counter increments each cycle. At count THINK_CYCLES-1 -> SCAN with line index 0.
- SCAN: evaluates one line per cycle for 8 cycles, in order: (1,2,3) (4,5,6) (7,8,9) (1,4,7) (2,5,8) (3,6,9) (1,5,9) (3,5,7).
  - A line with two CPU_MARK cells and one empty cell records that empty cell as the win candidate. Only the first such line is kept.
  - A line with two opponent cells and one empty cell records the block candidate. Only the first such line is kept.
  - After the 8th line -> PICK.
- PICK (1 cycle): chooses the move in priority order: win candidate, block candidate, cell 5 if empty, first empty of 1,3,7,9, first empty of 2,4,6,8.
  - Registers move_pos and asserts move_valid from the next cycle -> ISSUE.
  - If no cell is empty: move_pos=0, no request, -> WAIT_TURN.
- Latency from the IDLE->THINK transition to first move_valid high: THINK_CYCLES + 8 + 1 cycles.
- ISSUE: move_valid and move_pos are held stable until a response arrives.
  - move_ack: move_valid=0 next cycle, move_pos keeps its value, -> WAIT_TURN.
  - move_rej: move_valid=0 next cycle, candidates cleared, -> SCAN (no repeat of the think delay).
  - move_ack and move_rej in the same cycle: ack wins.
- WAIT_TURN -> IDLE once cpu_turn=0 or game_over=1. This prevents a double move while the game updates the turn.
- Abort: enable=0 or game_over=1 in THINK, SCAN, PICK or ISSUE -> IDLE next cycle, with move_valid=0 and move_pos=0. A move_ack arriving in that same cycle is ignored.
- The board is sampled live in every SCAN cycle. A board change mid-scan is tolerated because the game rejects an illegal cell and the rejection triggers a rescan.
- Cells with code 2'b11 count as occupied and are never chosen.

Optional Feature:
- Macro: CPU_LFSR_EN.
- When defined:
  - A free-running 8-bit Galois LFSR (taps 8,6,5,4; seed 8'h5A on reset) advances every clk.
  - The PICK fallback, used only when there is no win or block candidate, takes the first empty cell scanning cyclically from cell ((lfsr mod 9)+1) upward.
  - Win and block priority are unchanged.
- When undefined: the fixed centre/corner/edge fallback applies and no LFSR logic is present.

Test Plan (THINK_CYCLES=4):
- Empty board, enable=1, cpu_turn=1 -> move_valid rises 13 cycles after THINK entry with move_pos=5; ack -> move_valid low next cycle, busy stays high until cpu_turn=0.
- board X at 1 and 2, O at 5 -> move_pos=3 (block).
- board O at 1 and 5, X at 2 and 3 -> move_pos=9 (win beats block on line 4,5,6? none; diag 1,5,9 win).
- X at 5, all else empty -> move_pos=1 (first empty corner); respond move_rej with X placed at 1 -> rescan, move_pos=3 without a think delay.
- game_over pulses during ISSUE -> move_valid=0 and move_pos=0 the next cycle, state IDLE; an ack in the same cycle has no effect.
- rst asserted mid-SCAN asynchronously -> all outputs 0 immediately; after release no request until a fresh cpu_turn.
